// File: rtl/note_display_sequencer_if.sv
// Control bus between the note-lane sequencer, the game timing logic and the display datapath.
interface note_display_sequencer_if;
    logic        start;
    logic        beatTick;
    logic        shiftSong;
    logic        loadDefault;
    logic        writeDefault;
    logic        loadStartAddress;
    logic        loadX;
    logic        loadY;
    logic        writeToScreen;
    logic [13:0] gridCounter;
    logic [3:0]  boxCounter;
    logic [15:0] pixelCount;
    logic        busy;
    logic        frameDone;
    logic        overrun;

    // Sequencer side: takes timing pulses, drives strobes and counters.
    modport master (
        input  start, beatTick,
        output shiftSong, loadDefault, writeDefault, loadStartAddress,
               loadX, loadY, writeToScreen, gridCounter, boxCounter,
               pixelCount, busy, frameDone, overrun
    );

    // Timing/datapath side: issues pulses, consumes strobes and counters.
    modport slave (
        output start, beatTick,
        input  shiftSong, loadDefault, writeDefault, loadStartAddress,
               loadX, loadY, writeToScreen, gridCounter, boxCounter,
               pixelCount, busy, frameDone, overrun
    );
endinterface

// File: rtl/note_display_sequencer.sv
// Moore FSM sequencing background draw, per-beat song shift and per-box pixel redraw.
module note_display_sequencer #(
    parameter int GRID_PIXELS = 8192,
    parameter int NUM_BOXES   = 3,
    parameter int BOX_PIXELS  = 400
) (
    input  logic clock,
    input  logic resetn,
    note_display_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        WAIT_START, IDLE, D_ADDR, D_LOAD, D_WRITE, SHIFT,
        B_ADDR, B_LOAD, P_CALC, P_X, P_Y, P_WRITE, DONE
    } stateT;

    localparam logic [13:0] LAST_GRID  = 14'(GRID_PIXELS - 1);
    localparam logic [3:0]  LAST_BOX   = 4'(NUM_BOXES - 1);
    localparam logic [15:0] LAST_PIXEL = 16'(BOX_PIXELS - 1);

    stateT       state;
    stateT       nextState;
    logic [13:0] gridCount;
    logic [3:0]  boxCount;
    logic [15:0] pixelCount;
    logic        pending;
    logic        overrunFlag;
    logic        isBusy;

    logic lastGrid;
    logic lastBox;
    logic lastPixel;

    assign lastGrid  = (gridCount == LAST_GRID);
    assign lastBox   = (boxCount == LAST_BOX);
    assign lastPixel = (pixelCount == LAST_PIXEL);
    assign isBusy    = (state != WAIT_START) && (state != IDLE);

    // State register.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) state <= WAIT_START;
        else        state <= nextState;
    end

    // Next-state decode; start outranks a beat in IDLE, ROM/adder latency covered by spacer states.
    always_comb begin
        nextState = state;
        case (state)
            WAIT_START: if (bus.start) nextState = D_ADDR;
            IDLE: begin
                if (bus.start)                     nextState = D_ADDR;
                else if (pending || bus.beatTick)  nextState = SHIFT;
            end
            D_ADDR:  nextState = D_LOAD;
            D_LOAD:  nextState = D_WRITE;
            D_WRITE: nextState = lastGrid ? IDLE : D_ADDR;
            SHIFT:   nextState = B_ADDR;
            B_ADDR:  nextState = B_LOAD;
            B_LOAD:  nextState = P_CALC;
            P_CALC:  nextState = P_X;
            P_X:     nextState = P_Y;
            P_Y:     nextState = P_WRITE;
            P_WRITE: begin
                if (!lastPixel)    nextState = P_CALC;
                else if (!lastBox) nextState = B_ADDR;
                else               nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = WAIT_START;
        endcase
    end

    // Strobes decoded from the state register alone.
    always_comb begin
        bus.shiftSong        = 1'b0;
        bus.loadDefault      = 1'b0;
        bus.writeDefault     = 1'b0;
        bus.loadStartAddress = 1'b0;
        bus.loadX            = 1'b0;
        bus.loadY            = 1'b0;
        bus.writeToScreen    = 1'b0;
        bus.frameDone        = 1'b0;
        case (state)
            D_LOAD:  bus.loadDefault = 1'b1;
            D_WRITE: begin
                bus.writeToScreen = 1'b1;
                bus.writeDefault  = 1'b1;
            end
            SHIFT:   bus.shiftSong = 1'b1;
            B_LOAD:  bus.loadStartAddress = 1'b1;
            P_X:     bus.loadX = 1'b1;
            P_Y:     bus.loadY = 1'b1;
            P_WRITE: bus.writeToScreen = 1'b1;
            DONE:    bus.frameDone = 1'b1;
            default: ;
        endcase
    end

    // Grid, box and pixel counters; each wraps to 0 on its last value.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            gridCount  <= '0;
            boxCount   <= '0;
            pixelCount <= '0;
        end else begin
            case (state)
                D_WRITE: gridCount <= lastGrid ? 14'd0 : gridCount + 14'd1;
                SHIFT: begin
                    boxCount   <= '0;
                    pixelCount <= '0;
                end
                P_WRITE: begin
                    if (!lastPixel) begin
                        pixelCount <= pixelCount + 16'd1;
                    end else begin
                        pixelCount <= '0;
                        boxCount   <= lastBox ? 4'd0 : boxCount + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-deep beat queue; a second beat while one is queued is dropped and flagged.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            pending     <= 1'b0;
            overrunFlag <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                if (bus.beatTick) pending <= 1'b1;
            end else if (pending || bus.beatTick) begin
                pending <= 1'b0;
            end
        end else if (isBusy && bus.beatTick) begin
            if (pending) overrunFlag <= 1'b1;
            else         pending     <= 1'b1;
        end
    end

    assign bus.gridCounter = gridCount;
    assign bus.boxCounter  = boxCount;
    assign bus.pixelCount  = pixelCount;
    assign bus.busy        = isBusy;
    assign bus.overrun     = overrunFlag;
endmodule

// File: tb/tb_note_display_sequencer.sv
// Self-checking bench: activity/offset reference model compared every cycle, plus directed literal checks.
module tb_note_display_sequencer;
    localparam int G         = 4;
    localparam int NB        = 3;
    localparam int BP        = 2;
    localparam int BOX_LEN   = 2 + 4 * BP;
    localparam int DRAW_LEN  = 3 * G;
    localparam int BEAT_LEN  = NB * BOX_LEN + 2;

    logic clock = 1'b0;
    logic resetn;
    note_display_sequencer_if bus();

    note_display_sequencer #(.GRID_PIXELS(G), .NUM_BOXES(NB), .BOX_PIXELS(BP)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit benchDone = 1'b0;

    // Model: 0 waiting for start, 1 idle, 2 background draw, 3 beat redraw; mOff = cycles into activity.
    int mMode    = 0;
    int mOff     = 0;
    bit mPending = 1'b0;
    bit mOverrun = 1'b0;

    logic [43:0] dutVec;
    assign dutVec = {bus.shiftSong, bus.loadDefault, bus.writeDefault, bus.loadStartAddress,
                     bus.loadX, bus.loadY, bus.writeToScreen, bus.busy, bus.frameDone,
                     bus.overrun, bus.gridCounter, bus.boxCounter, bus.pixelCount};

    function automatic logic [43:0] modelVec(int mode, int off, bit ovr);
        logic sh, ld, wd, ls, lx, ly, ws, bz, fd;
        logic [13:0] g;
        logic [3:0]  b;
        logic [15:0] p;
        int j, r, q;
        {sh, ld, wd, ls, lx, ly, ws, bz, fd} = '0;
        g = '0; b = '0; p = '0;
        if (mode == 2) begin
            bz = 1'b1;
            g  = 14'(off / 3);
            if (off % 3 == 1) ld = 1'b1;
            if (off % 3 == 2) begin ws = 1'b1; wd = 1'b1; end
        end else if (mode == 3) begin
            bz = 1'b1;
            if (off == 0) sh = 1'b1;
            else if (off == BEAT_LEN - 1) fd = 1'b1;
            else begin
                j = off - 1;
                b = 4'(j / BOX_LEN);
                r = j % BOX_LEN;
                if (r == 1) ls = 1'b1;
                else if (r >= 2) begin
                    q = r - 2;
                    p = 16'(q / 4);
                    if (q % 4 == 1) lx = 1'b1;
                    if (q % 4 == 2) ly = 1'b1;
                    if (q % 4 == 3) ws = 1'b1;
                end
            end
        end
        return {sh, ld, wd, ls, lx, ly, ws, bz, fd, ovr, g, b, p};
    endfunction

    // Model advance on each rising clock or reset assertion.
    initial forever begin
        @(posedge clock or posedge resetn);
        if (resetn) begin
            mMode = 0; mOff = 0; mPending = 1'b0; mOverrun = 1'b0;
        end else begin
            case (mMode)
                0: if (bus.start) begin mMode = 2; mOff = 0; end
                1: begin
                    if (bus.start) begin
                        mMode = 2; mOff = 0;
                        if (bus.beatTick) mPending = 1'b1;
                    end else if (mPending || bus.beatTick) begin
                        mMode = 3; mOff = 0; mPending = 1'b0;
                    end
                end
                default: begin
                    if (bus.beatTick) begin
                        if (mPending) mOverrun = 1'b1;
                        else          mPending = 1'b1;
                    end
                    mOff++;
                    if ((mMode == 2 && mOff == DRAW_LEN) || (mMode == 3 && mOff == BEAT_LEN)) begin
                        mMode = 1; mOff = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clock);
        if (!benchDone) begin
            checks++;
            if (dutVec !== modelVec(mMode, mOff, mOverrun)) begin
                failures++;
                $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, dutVec,
                         modelVec(mMode, mOff, mOverrun));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse(input bit s, input bit t);
        @(posedge clock); #2;
        bus.start = s; bus.beatTick = t;
        @(posedge clock); #2;
        bus.start = 1'b0; bus.beatTick = 1'b0;
    endtask

    task automatic countWhileBusy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (!bus.busy) break;
            n++;
        end
    endtask

    task automatic cyclesToFrameDone(output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            n++;
            if (bus.frameDone) begin found = 1'b1; break; end
        end
        if (!found) n = -1;
    endtask

    task automatic cyclesToShift(output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            n++;
            if (bus.shiftSong) begin found = 1'b1; break; end
        end
        if (!found) n = -1;
    endtask

    task automatic framesUntilIdle(output int frames);
        int lowRun = 0;
        frames = 0;
        for (int i = 0; i < 1000 && lowRun < 3; i++) begin
            @(negedge clock);
            if (bus.frameDone) frames++;
            lowRun = bus.busy ? 0 : lowRun + 1;
        end
        if (lowRun < 3) frames = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit prevS, prevT;
        resetn = 1'b1;
        bus.start = 1'b0;
        bus.beatTick = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock); #2 resetn = 1'b0;
        @(negedge clock);
        check("reset_outputs", 64'(dutVec), 64'd0);

        // Beat while waiting for start does nothing.
        pulse(1'b0, 1'b1);
        repeat (4) @(negedge clock);
        check("wait_start_beat_busy", 64'(bus.busy), 64'd0);

        // Background draw.
        pulse(1'b1, 1'b0);
        countWhileBusy(n);
        check("draw_busy_cycles", 64'(n), 64'd12);
        check("draw_grid_after", 64'(bus.gridCounter), 64'd0);

        // Single beat redraw latency.
        pulse(1'b0, 1'b1);
        cyclesToFrameDone(n);
        check("beat_latency", 64'(n), 64'd32);
        check("beat_no_overrun", 64'(bus.overrun), 64'd0);

        // One beat queued during a redraw.
        repeat (3) @(posedge clock);
        pulse(1'b0, 1'b1);
        repeat (5) @(posedge clock);
        pulse(1'b0, 1'b1);
        cyclesToFrameDone(n);
        cyclesToShift(n);
        check("pending_shift_gap", 64'(n), 64'd2);
        cyclesToFrameDone(n);
        check("pending_redraw_len", 64'(n), 64'd31);
        check("pending_no_overrun", 64'(bus.overrun), 64'd0);

        // Two extra beats during one redraw.
        repeat (3) @(posedge clock);
        pulse(1'b0, 1'b1);
        repeat (3) @(posedge clock);
        pulse(1'b0, 1'b1);
        repeat (3) @(posedge clock);
        pulse(1'b0, 1'b1);
        check("overrun_set", 64'(bus.overrun), 64'd1);
        framesUntilIdle(n);
        check("overrun_frames", 64'(n), 64'd2);
        check("overrun_sticky", 64'(bus.overrun), 64'd1);

        // Start and beat together: draw first, then the queued beat.
        pulse(1'b1, 1'b1);
        countWhileBusy(n);
        check("start_beat_draw_cycles", 64'(n), 64'd12);
        @(negedge clock);
        check("start_beat_then_shift", 64'(bus.shiftSong), 64'd1);
        cyclesToFrameDone(n);
        check("start_beat_redraw_len", 64'(n), 64'd31);

        // Asynchronous reset mid-redraw at box 1, pixel 1.
        repeat (2) @(posedge clock);
        pulse(1'b0, 1'b1);
        n = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.boxCounter == 4'd1 && bus.pixelCount == 16'd1) begin n = i; break; end
        end
        check("reached_box1_pixel1", 64'(n >= 0), 64'd1);
        #2 resetn = 1'b1;
        #1 check("async_reset_outputs", 64'(dutVec), 64'd0);
        @(negedge clock); #2 resetn = 1'b0;
        pulse(1'b0, 1'b1);
        repeat (4) @(negedge clock);
        check("post_reset_beat_ignored", 64'(bus.busy), 64'd0);
        pulse(1'b1, 1'b0);
        countWhileBusy(n);
        check("post_reset_draw_cycles", 64'(n), 64'd12);

        // Randomized pulses with periodic resets; the compare process checks every cycle.
        prevS = 1'b0; prevT = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #2;
            if (i % 500 == 499) resetn = 1'b1;
            else                resetn = 1'b0;
            bus.start    = !prevS && ($urandom_range(0, 99) < 2);
            bus.beatTick = !prevT && ($urandom_range(0, 99) < 4);
            prevS = bus.start;
            prevT = bus.beatTick;
        end
        @(posedge clock); #2;
        bus.start = 1'b0; bus.beatTick = 1'b0; resetn = 1'b0;
        repeat (5) @(negedge clock);

        benchDone = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
